// File: rtl/fft_butterfly_sequencer_if.sv
`default_nettype none
// ============================================================================
// fft_butterfly_sequencer_if : start/done handshake plus RAM/ROM address bus
// Revision 1.0
// ============================================================================
interface fft_butterfly_sequencer_if #(
   parameter int LOG2N = 4
);
   logic             Start;
   logic             RdEn;
   logic [LOG2N-1:0] RdAddrA;
   logic [LOG2N-1:0] RdAddrB;
   logic [LOG2N-2:0] TwAddr;
   logic             WrEn;
   logic [LOG2N-1:0] WrAddrY;
   logic [LOG2N-1:0] WrAddrZ;
   logic [LOG2N-1:0] Stage;
   logic             Busy;
   logic             Done;

   modport master (
      input  Start,
      output RdEn, RdAddrA, RdAddrB, TwAddr,
      output WrEn, WrAddrY, WrAddrZ,
      output Stage, Busy, Done
   );

   modport slave (
      output Start,
      input  RdEn, RdAddrA, RdAddrB, TwAddr,
      input  WrEn, WrAddrY, WrAddrZ,
      input  Stage, Busy, Done
   );
endinterface
`default_nettype wire

// File: rtl/fft_butterfly_sequencer.sv
`default_nettype none
// ============================================================================
// fft_butterfly_sequencer : in-place radix-2 DIT FFT operand/twiddle/write sequencer
// Revision 1.0
// ============================================================================
module fft_butterfly_sequencer #(
   parameter int LOG2N    = 4,
   parameter int MEM_LAT  = 1,
   parameter int BFLY_LAT = 5
) (
   input  logic                     Clk,
   input  logic                     Rst,
   fft_butterfly_sequencer_if.master bus
);

   localparam int c_d  = MEM_LAT + BFLY_LAT;
   localparam int c_cw = $clog2(c_d + 1);
   localparam int c_kw = LOG2N - 1;

   localparam logic [LOG2N-1:0] c_one    = LOG2N'(1);
   localparam logic [LOG2N-1:0] c_last_s = LOG2N'(LOG2N - 1);
   localparam logic [c_kw-1:0]  c_k_one  = c_kw'(1);
   localparam logic [c_kw-1:0]  c_last_k = '1;
   localparam logic [c_cw-1:0]  c_drain  = c_cw'(c_d);
   localparam logic [c_cw-1:0]  c_c_one  = c_cw'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t           r_state;
   logic [LOG2N-1:0] r_s;
   logic [c_kw-1:0]  r_k;
   logic [c_cw-1:0]  r_cnt;
   logic             r_rd_en;
   logic [LOG2N-1:0] r_rd_a;
   logic [LOG2N-1:0] r_rd_b;
   logic [c_kw-1:0]  r_tw;
   logic             r_busy;
   logic             r_done;

   logic             r_pv [c_d];
   logic [LOG2N-1:0] r_pa [c_d];
   logic [LOG2N-1:0] r_pb [c_d];

   logic [LOG2N-1:0] w_iss_s;
   logic [LOG2N-1:0] w_k;
   logic [LOG2N-1:0] w_half;
   logic [LOG2N-1:0] w_pos;
   logic [LOG2N-1:0] w_a;
   logic [LOG2N-1:0] w_b;
   logic [c_kw-1:0]  w_tw;

   // Butterfly about to be issued: the first of the next stage while draining,
   // otherwise the current (s,k); r_s and r_k are zero in IDLE.
   always_comb begin
      w_iss_s = (r_state == S_DRAIN) ? r_s + c_one : r_s;
      w_k     = (r_state == S_ISSUE) ? {1'b0, r_k} : '0;
      w_half  = c_one << w_iss_s;
      w_pos   = w_k & (w_half - c_one);
      w_a     = ((w_k >> w_iss_s) << (w_iss_s + c_one)) | w_pos;
      w_b     = w_a | w_half;
      w_tw    = c_kw'(w_pos << (c_last_s - w_iss_s));
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= S_IDLE;
         r_s     <= '0;
         r_k     <= '0;
         r_cnt   <= '0;
         r_rd_en <= 1'b0;
         r_rd_a  <= '0;
         r_rd_b  <= '0;
         r_tw    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_rd_en <= 1'b0;
         r_rd_a  <= '0;
         r_rd_b  <= '0;
         r_tw    <= '0;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_s <= '0;
               r_k <= '0;
               if (bus.Start) begin
                  r_state <= S_ISSUE;
                  r_busy  <= 1'b1;
                  r_rd_en <= 1'b1;
                  r_rd_a  <= w_a;
                  r_rd_b  <= w_b;
                  r_tw    <= w_tw;
                  r_k     <= c_k_one;
               end
            end
            S_ISSUE: begin
               r_rd_en <= 1'b1;
               r_rd_a  <= w_a;
               r_rd_b  <= w_b;
               r_tw    <= w_tw;
               if (r_k == c_last_k) begin
                  r_state <= S_DRAIN;
                  r_cnt   <= c_drain;
                  r_k     <= '0;
               end else begin
                  r_k <= r_k + c_k_one;
               end
            end
            S_DRAIN: begin
               // Counter hits zero on the cycle the stage's last write is issued.
               if (r_cnt == '0) begin
                  if (r_s != c_last_s) begin
                     r_state <= S_ISSUE;
                     r_s     <= r_s + c_one;
                     r_k     <= c_k_one;
                     r_rd_en <= 1'b1;
                     r_rd_a  <= w_a;
                     r_rd_b  <= w_b;
                     r_tw    <= w_tw;
                  end else begin
                     r_state <= S_FINISH;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - c_c_one;
               end
            end
            S_FINISH: begin
               r_state <= S_IDLE;
               r_s     <= '0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Write side is a pure delay of the issue side; nothing is recomputed.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < c_d; i++) begin
            r_pv[i] <= 1'b0;
            r_pa[i] <= '0;
            r_pb[i] <= '0;
         end
      end else begin
         r_pv[0] <= r_rd_en;
         r_pa[0] <= r_rd_a;
         r_pb[0] <= r_rd_b;
         for (int i = 1; i < c_d; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pa[i] <= r_pa[i-1];
            r_pb[i] <= r_pb[i-1];
         end
      end
   end

   assign bus.RdEn    = r_rd_en;
   assign bus.RdAddrA = r_rd_a;
   assign bus.RdAddrB = r_rd_b;
   assign bus.TwAddr  = r_tw;
   assign bus.WrEn    = r_pv[c_d-1];
   assign bus.WrAddrY = r_pa[c_d-1];
   assign bus.WrAddrZ = r_pb[c_d-1];
   assign bus.Stage   = r_s;
   assign bus.Busy    = r_busy;
   assign bus.Done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fft_butterfly_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fft_butterfly_sequencer : directed + random Start/Rst against a cycle-level
// reference model, LOG2N=4 and LOG2N=3 instances in parallel. Revision 1.0
// ============================================================================
module tb_fft_butterfly_sequencer;

   localparam int c_d      = 6;
   localparam int c_cycles = 2600;

   logic Clk = 1'b0;
   logic Rst;

   always #5 Clk = ~Clk;

   fft_butterfly_sequencer_if #(.LOG2N(4)) b4 ();
   fft_butterfly_sequencer_if #(.LOG2N(3)) b3 ();

   fft_butterfly_sequencer #(.LOG2N(4), .MEM_LAT(1), .BFLY_LAT(5)) u_dut4 (
      .Clk (Clk),
      .Rst (Rst),
      .bus (b4.master)
   );

   fft_butterfly_sequencer #(.LOG2N(3), .MEM_LAT(1), .BFLY_LAT(5)) u_dut3 (
      .Clk (Clk),
      .Rst (Rst),
      .bus (b3.master)
   );

   int n_checks = 0;
   int n_errors = 0;

   int m_run   [2] = '{0, 0};
   int m_start [2] = '{0, 0};
   int m_rstz  [2] = '{0, 0};
   int m_wr    [2] = '{0, 0};
   int m_runs  [2] = '{0, 0};

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Butterfly issued t cycles after Start was sampled, straight from the
   // stage-period arithmetic and the group/pos address formulas.
   function automatic void model_bfly(input int l2n, input int t,
                                      output int en, output int a, output int b,
                                      output int tw, output int s);
      int n2, p, k, half, pos;
      n2 = 1 << (l2n - 1);
      p  = n2 + c_d;
      en = 0; a = 0; b = 0; tw = 0; s = 0;
      if (t >= 1) begin
         s = (t - 1) / p;
         k = (t - 1) % p;
         if (s < l2n && k < n2) begin
            en   = 1;
            half = 1 << s;
            pos  = k % half;
            a    = (k / half) * 2 * half + pos;
            b    = a + half;
            tw   = pos << (l2n - 1 - s);
         end
      end
   endfunction

   task automatic mon(input int id, input int c, input int l2n,
                      input int rd, input int a, input int b, input int tw,
                      input int wr, input int y, input int z, input int stg,
                      input int busy, input int done);
      int t, tt, n2;
      int een, ea, eb, etw, es;
      int wen, wa, wb, wtw, ws;
      string p;
      n2 = 1 << (l2n - 1);
      tt = l2n * (n2 + c_d);
      p  = $sformatf("c%0d L%0d", c, l2n);
      if (m_rstz[id] != 0) begin
         check({p, " rst_rden"},  rd,   0);
         check({p, " rst_addra"}, a,    0);
         check({p, " rst_addrb"}, b,    0);
         check({p, " rst_tw"},    tw,   0);
         check({p, " rst_wren"},  wr,   0);
         check({p, " rst_wry"},   y,    0);
         check({p, " rst_wrz"},   z,    0);
         check({p, " rst_stage"}, stg,  0);
         check({p, " rst_busy"},  busy, 0);
         check({p, " rst_done"},  done, 0);
      end else if (m_run[id] == 0) begin
         check({p, " idle_rden"}, rd,   0);
         check({p, " idle_wren"}, wr,   0);
         check({p, " idle_busy"}, busy, 0);
         check({p, " idle_done"}, done, 0);
      end else begin
         t = c - m_start[id];
         model_bfly(l2n, t, een, ea, eb, etw, es);
         check({p, " rden"}, rd, een);
         if (een != 0) begin
            check({p, " addra"}, a,   ea);
            check({p, " addrb"}, b,   eb);
            check({p, " twaddr"}, tw, etw);
            check({p, " stage"}, stg, es);
         end
         model_bfly(l2n, t - c_d, wen, wa, wb, wtw, ws);
         check({p, " wren"}, wr, wen);
         if (wen != 0) begin
            check({p, " wry"}, y, wa);
            check({p, " wrz"}, z, wb);
         end
         if (wr != 0) m_wr[id]++;
         check({p, " busy"}, busy, int'(t <= tt));
         check({p, " done"}, done, int'(t == tt + 1));
         if (t == tt + 1) begin
            check({p, " wr_count"}, m_wr[id], l2n * n2);
            m_runs[id]++;
         end
      end
   endtask

   // Inputs st/rs are those sampled at the clock edge ending cycle c.
   task automatic model_step(input int id, input int c, input int l2n,
                             input logic st, input logic rs);
      int tt, accept;
      tt = l2n * ((1 << (l2n - 1)) + c_d);
      if (rs) begin
         m_run[id]  = 0;
         m_rstz[id] = 1;
      end else begin
         m_rstz[id] = 0;
         accept     = (m_run[id] == 0) ? 1 : 0;
         if (m_run[id] != 0 && c >= m_start[id] + tt + 1) m_run[id] = 0;
         if (accept != 0 && st) begin
            m_run[id]   = 1;
            m_start[id] = c;
            m_wr[id]    = 0;
         end
      end
   endtask

   initial begin
      logic st, rs;
      Rst      = 1'b1;
      b4.Start = 1'b1;
      b3.Start = 1'b1;
      model_step(0, 0, 4, 1'b1, 1'b1);
      model_step(1, 0, 3, 1'b1, 1'b1);
      for (int c = 1; c <= c_cycles; c++) begin
         @(negedge Clk);
         mon(0, c, 4, int'(b4.RdEn), int'(b4.RdAddrA), int'(b4.RdAddrB), int'(b4.TwAddr),
             int'(b4.WrEn), int'(b4.WrAddrY), int'(b4.WrAddrZ), int'(b4.Stage),
             int'(b4.Busy), int'(b4.Done));
         mon(1, c, 3, int'(b3.RdEn), int'(b3.RdAddrA), int'(b3.RdAddrB), int'(b3.TwAddr),
             int'(b3.WrEn), int'(b3.WrAddrY), int'(b3.WrAddrZ), int'(b3.Stage),
             int'(b3.Busy), int'(b3.Done));
         if (c < 160) begin
            // Run from 10; stray Starts at +10/+40/+57; restart at +58; Rst at +20 of that run.
            rs = (c < 5) || (c == 88);
            st = (c < 5) || (c == 10) || (c == 20) || (c == 50) || (c == 67) ||
                 (c == 68) || (c == 95);
         end else begin
            rs = ($urandom_range(0, 499) == 0);
            st = ($urandom_range(0, 19) == 0);
         end
         Rst      = rs;
         b4.Start = st;
         b3.Start = st;
         model_step(0, c, 4, st, rs);
         model_step(1, c, 3, st, rs);
      end
      check("runs_done_L4", int'(m_runs[0] >= 3), 1);
      check("runs_done_L3", int'(m_runs[1] >= 3), 1);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fft_butterfly_sequencer.md
# fft_butterfly_sequencer

Control and address generator for the in-place radix-2 DIT FFT. It is the operand-side counterpart of the butterfly multiply-add unit. It issues read addresses for the A/B operand pair and the twiddle index for every butterfly, tracks each butterfly through memory and butterfly pipeline latency, and issues the matching Y/Z write-back addresses. It sits between the FFT start/done handshake and the data RAM, twiddle ROM and butterfly unit. Bit-reversed input ordering is handled upstream.

## Interface
- LOG2N, 4, log2 of FFT length N (N = 2^LOG2N, N/2 butterflies per stage, LOG2N stages)
- MEM_LAT, 1, data RAM / twiddle ROM read latency in cycles
- BFLY_LAT, 5, butterfly unit latency from operand inputs to Y/Z outputs
- Clk  in  1  single clock, all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- Start  in  1  run request, sampled only in IDLE
- RdEn  out  1  operand read strobe (RAM ports A and B, twiddle ROM)
- RdAddrA  out  LOG2N  address of operand A
- RdAddrB  out  LOG2N  address of operand B
- TwAddr  out  LOG2N-1  twiddle ROM index
- WrEn  out  1  result write strobe
- WrAddrY  out  LOG2N  write address of Y (= A address of the same butterfly)
- WrAddrZ  out  LOG2N  write address of Z (= B address of the same butterfly)
- Stage  out  LOG2N  current issue stage s
- Busy  out  1  run in progress
- Done  out  1  one-cycle completion pulse

## Operation
- D = MEM_LAT + BFLY_LAT. This is the issue-to-write distance.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
  - IDLE with Start=1: go to ISSUE with s=0, k=0.
  - ISSUE: on each cycle, assert RdEn for butterfly (s,k) and increment k. After k=N/2-1 is issued, go to DRAIN.
  - DRAIN: wait until the write for the last butterfly of the stage has been issued. On that cycle, if s<LOG2N-1, increment s, clear k, and go to ISSUE; otherwise go to FINISH.
  - FINISH: assert Done for one cycle, then go to IDLE.
- Address generation, with half=2^s, pos = k mod half, group = k div half:
  - RdAddrA = group·2·half + pos
  - RdAddrB = RdAddrA + half
  - TwAddr = pos << (LOG2N-1-s)
- Write tracking uses a D-deep shift register carrying {valid, addrA, addrB}. WrEn, WrAddrY and WrAddrZ are its output. No addresses are recomputed on the write side.
- Stage-to-stage hazard: the next stage never reads before every write of the current stage has been issued. There is full drain, no forwarding.
- Start in ISSUE, DRAIN or FINISH is ignored, with no queuing.
- All outputs are registered.

## Timing
- Reset: every output is 0 on the cycle after Rst is sampled high. FSM goes to IDLE, s=k=0, and the write pipeline valid bits are cleared. Rst mid-run aborts the run: no WrEn and no Done after reset.
- Start is sampled high at the end of cycle 0. The first RdEn is in cycle 1.
- Stage period = N/2 + D cycles:
  - Stage s RdEn occupies cycles 1+s(N/2+D) through s(N/2+D)+N/2.
  - WrEn occupies the same cycles shifted by +D.
  - RdEn is low for D cycles between stages.
- The last WrEn is in cycle T = LOG2N·(N/2+D). Done is high in cycle T+1.
- Busy is high in cycles 1..T and low in the Done cycle.
- Defaults (N=16, D=6): T=56, Done in cycle 57.
- Every WrEn equals the RdEn of the same butterfly delayed exactly D cycles, with identical addresses.

## Test plan
- Reset: hold Rst high with Start=1. Required: all outputs 0 and no RdEn. Release Rst with Start=0: still idle.
- Default run, Start at cycle 0. Required:
  - RdEn in cycles 1–8, 15–22, 29–36 and 43–50.
  - Cycle 1: A=0, B=1, Tw=0.
  - Stage 1, k=1: A=1, B=3, Tw=4.
  - Stage 2, k=5: A=9, B=13, Tw=2.
  - Stage 3, k=7: A=7, B=15, Tw=7.
  - Done only in cycle 57, Busy in cycles 1–56.
- Write tracking: in every cycle c with WrEn=1, WrAddrY/WrAddrZ equal RdAddrA/RdAddrB of cycle c−6. Total WrEn count is 32, with no write in a stage's RdEn window from the previous stage.
- Start pulses at cycles 10, 40 and 57. Required: run unaffected, Done in cycle 57 only, no restart. Start at cycle 58 (IDLE) begins a new run with RdEn in cycle 59.
- Rst at cycle 20. Required: outputs 0 from cycle 21, no further WrEn, no Done. A subsequent Start produces a full, correct run.
- Parameter sweep LOG2N=3, MEM_LAT=1, BFLY_LAT=5. Required: T=30, Done in cycle 31, and stage 2 k=3 gives A=3, B=7, Tw=3.
